// File: rtl/pixel_sram_arbiter.sv
// Framebuffer SRAM arbiter: the pixel engine owns the SRAM whenever it asks;
// buffered CPU writes and single CPU reads fill the cycles it leaves free.
module pixel_sram_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          gpu_req,
  input  logic [ADDR_W-1:0]             gpu_addr,
  output logic [DATA_W-1:0]             gpu_data,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  input  logic [ADDR_W-1:0]             cpu_wr_addr,
  input  logic [DATA_W-1:0]             cpu_wr_data,
  input  logic                          cpu_rd_start,
  input  logic [ADDR_W-1:0]             cpu_rd_addr,
  output logic                          cpu_busy,
  output logic                          cpu_rd_done,
  output logic [DATA_W-1:0]             cpu_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   wr_stall_cycles,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  output logic                          sram_we,
  input  logic [DATA_W-1:0]             sram_rdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic {IDLE, RD_PEND} state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [ADDR_W-1:0]   rd_addr_reg;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                rd_grant;

  assign full         = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty        = (fifo_level == '0);
  assign cpu_wr_ready = !full && (state == IDLE);
  assign push         = cpu_wr_valid && cpu_wr_ready;
  assign cpu_busy     = (state == RD_PEND);
  assign gpu_data     = sram_rdata;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle SRAM arbitration: GPU, then CPU read, then FIFO drain
  always_comb begin
    state_next = state;
    rd_grant   = 1'b0;
    pop        = 1'b0;
    sram_addr  = gpu_addr;
    sram_wdata = fifo_data[rd_ptr];
    sram_we    = 1'b0;
    case (state)
      IDLE:    if (cpu_rd_start) state_next = RD_PEND;
      RD_PEND: ;
      default: state_next = IDLE;
    endcase
    if (!gpu_req) begin
      if (state == RD_PEND && empty) begin
        rd_grant   = 1'b1;
        sram_addr  = rd_addr_reg;
        state_next = IDLE;
      end else if (!empty) begin
        pop       = 1'b1;
        sram_addr = fifo_addr[rd_ptr];
        sram_we   = 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the level gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_wr_addr;
      fifo_data[wr_ptr] <= cpu_wr_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
      else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
    end
  end

  // CPU read address capture, read data register and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_reg <= '0;
      cpu_rd_data <= '0;
      cpu_rd_done <= 1'b0;
    end else begin
      if (state == IDLE && cpu_rd_start) rd_addr_reg <= cpu_rd_addr;
      if (rd_grant) cpu_rd_data <= sram_rdata;
      cpu_rd_done <= rd_grant;
    end
  end

  // Saturating count of cycles a CPU write was offered but refused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_stall_cycles <= '0;
    end else if (cpu_wr_valid && !cpu_wr_ready && wr_stall_cycles != 16'hFFFF) begin
      wr_stall_cycles <= wr_stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_sram_arbiter.sv
// Directed bench for pixel_sram_arbiter with a behavioural SRAM model.
module tb_pixel_sram_arbiter;

  logic        clk;
  logic        reset;
  logic        gpu_req;
  logic [16:0] gpu_addr;
  logic [7:0]  gpu_data;
  logic        cpu_wr_valid;
  logic        cpu_wr_ready;
  logic [16:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_rd_start;
  logic [16:0] cpu_rd_addr;
  logic        cpu_busy;
  logic        cpu_rd_done;
  logic [7:0]  cpu_rd_data;
  logic [2:0]  fifo_level;
  logic [15:0] wr_stall_cycles;
  logic [16:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic        sram_we;
  logic [7:0]  sram_rdata;

  logic [7:0]  mem [0:131071];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          viol = 0;
  int          done_cnt = 0;
  logic [16:0] log_addr [$];
  logic [7:0]  log_data [$];
  int          log_cyc  [$];

  pixel_sram_arbiter #(.ADDR_W(17), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_data(gpu_data),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready), .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_start(cpu_rd_start), .cpu_rd_addr(cpu_rd_addr),
    .cpu_busy(cpu_busy), .cpu_rd_done(cpu_rd_done), .cpu_rd_data(cpu_rd_data),
    .fifo_level(fifo_level), .wr_stall_cycles(wr_stall_cycles), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial SRAM contents: a fixed function of the address
  function automatic logic [7:0] pat(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // SRAM model: combinational read, write on the rising edge
  assign sram_rdata = mem[sram_addr];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    cyc++;
  end

  // Mid-cycle monitors: write log, GPU-collision count, done pulse count
  always @(negedge clk) begin
    if (sram_we === 1'b1) begin
      log_addr.push_back(sram_addr);
      log_data.push_back(sram_wdata);
      log_cyc.push_back(cyc);
      if (gpu_req) viol++;
    end
    if (cpu_rd_done === 1'b1) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1; gpu_req = 1'b0; gpu_addr = 17'h00123;
    cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cpu_rd_start = 1'b0; cpu_rd_addr = '0;
    tick; tick;
    reset = 1'b0;
    @(negedge clk);
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    tests++; if (cpu_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", cpu_busy); end
    tests++; if (cpu_rd_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", cpu_rd_done); end
    tests++; if (cpu_rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data got %h exp 00", cpu_rd_data); end
    tests++; if (wr_stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_stall got %0d exp 0", wr_stall_cycles); end
    tests++; if (sram_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", sram_we); end
    tests++; if (cpu_wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", cpu_wr_ready); end
    tests++; if (sram_addr !== 17'h00123) begin fails++; $display("FAIL reset_sram_addr got %h exp 00123", sram_addr); end
    tests++; if (gpu_data !== 8'h1E) begin fails++; $display("FAIL reset_gpu_data got %h exp 1e", gpu_data); end
    #1 gpu_addr = 17'h1ABCD;
    #1;
    tests++; if (sram_addr !== 17'h1ABCD) begin fails++; $display("FAIL idle_track_addr got %h exp 1abcd", sram_addr); end
    tests++; if (gpu_data !== 8'h5A) begin fails++; $display("FAIL idle_gpu_data got %h exp 5a", gpu_data); end
  endtask

  task automatic test_fifo_full;
    tick;
    gpu_req = 1'b1; gpu_addr = 17'h00040;
    for (int i = 0; i < 4; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 17'(5 + i);
      cpu_wr_data  = 8'(8'h12 + 8'h22 * i);
      @(negedge clk);
      tests++; if (cpu_wr_ready !== 1'b1) begin fails++; $display("FAIL full_ready_%0d got %b exp 1", i, cpu_wr_ready); end
      tick;
    end
    cpu_wr_addr = 17'd9; cpu_wr_data = 8'h9A;
    @(negedge clk);
    tests++; if (cpu_wr_ready !== 1'b0) begin fails++; $display("FAIL full_fifth_ready got %b exp 0", cpu_wr_ready); end
    tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL full_level got %0d exp 4", fifo_level); end
    tests++; if (wr_stall_cycles !== 16'd0) begin fails++; $display("FAIL full_stall0 got %0d exp 0", wr_stall_cycles); end
    tick; tick; tick;
    @(negedge clk);
    tests++; if (wr_stall_cycles !== 16'd3) begin fails++; $display("FAIL full_stall3 got %0d exp 3", wr_stall_cycles); end
    tick;
    cpu_wr_valid = 1'b0;
    clear_log();
    gpu_req = 1'b0;
    repeat (4) begin @(negedge clk); tick; end
    @(negedge clk);
    tests++; if (log_addr.size() !== 4) begin fails++; $display("FAIL drain_count got %0d exp 4", log_addr.size()); end
    if (log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (log_addr[i] !== 17'(5 + i) || log_data[i] !== 8'(8'h12 + 8'h22 * i))
          begin fails++; $display("FAIL drain_order_%0d got %h/%h exp %h/%h", i, log_addr[i], log_data[i], 17'(5 + i), 8'(8'h12 + 8'h22 * i)); end
        tests++; if (log_cyc[i] !== log_cyc[0] + i) begin fails++; $display("FAIL drain_consec_%0d got %0d exp %0d", i, log_cyc[i], log_cyc[0] + i); end
      end
    end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL drain_level got %0d exp 0", fifo_level); end
    tests++; if (wr_stall_cycles !== 16'd4) begin fails++; $display("FAIL drain_stall got %0d exp 4", wr_stall_cycles); end
    tests++; if (viol !== 0) begin fails++; $display("FAIL drain_gpu_collision got %0d exp 0", viol); end
  endtask

  task automatic test_alternating;
    int  idx = 0;
    int  disturb = 0;
    bit  finished = 1'b0;
    bit  acc;
    clear_log();
    tick;
    for (int c = 0; c < 40 && !finished; c++) begin
      gpu_req      = (c % 2 == 0);
      gpu_addr     = 17'(32'h300 + c);
      cpu_wr_valid = (idx < 6);
      cpu_wr_addr  = 17'(32'h200 + idx);
      cpu_wr_data  = 8'(8'hC0 + idx);
      @(negedge clk);
      if (gpu_req && gpu_data !== pat(gpu_addr)) disturb++;
      acc = cpu_wr_valid && cpu_wr_ready;
      if (idx == 6 && fifo_level == 3'd0) finished = 1'b1;
      tick;
      if (acc) idx++;
    end
    cpu_wr_valid = 1'b0;
    tests++; if (!finished) begin fails++; $display("FAIL alt_timeout got idx %0d exp 6", idx); end
    tests++; if (disturb !== 0) begin fails++; $display("FAIL alt_gpu_disturbed got %0d exp 0", disturb); end
    tests++; if (log_addr.size() !== 6) begin fails++; $display("FAIL alt_write_count got %0d exp 6", log_addr.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (mem[17'(32'h200 + i)] !== 8'(8'hC0 + i))
        begin fails++; $display("FAIL alt_mem_%0d got %h exp %h", i, mem[17'(32'h200 + i)], 8'(8'hC0 + i)); end
    end
    tests++; if (viol !== 0) begin fails++; $display("FAIL alt_gpu_collision got %0d exp 0", viol); end
  endtask

  task automatic test_read_after_write;
    gpu_req = 1'b1; gpu_addr = 17'h00050;
    cpu_wr_valid = 1'b1; cpu_wr_addr = 17'h01000; cpu_wr_data = 8'hAB;
    tick;
    cpu_wr_valid = 1'b0; cpu_rd_start = 1'b1; cpu_rd_addr = 17'h01000;
    tick;
    cpu_rd_start = 1'b0;
    cpu_wr_valid = 1'b1; cpu_wr_addr = 17'h01001; cpu_wr_data = 8'h11;
    @(negedge clk);
    tests++; if (cpu_busy !== 1'b1) begin fails++; $display("FAIL raw_busy got %b exp 1", cpu_busy); end
    tests++; if (cpu_wr_ready !== 1'b0) begin fails++; $display("FAIL raw_ready got %b exp 0", cpu_wr_ready); end
    tests++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL raw_level got %0d exp 1", fifo_level); end
    tick;
    cpu_wr_valid = 1'b0; gpu_req = 1'b0;
    clear_log(); done_cnt = 0;
    @(negedge clk);
    tests++; if (sram_we !== 1'b1 || sram_addr !== 17'h01000) begin fails++; $display("FAIL raw_write_first got we %b addr %h exp 1 01000", sram_we, sram_addr); end
    tick;
    @(negedge clk);
    tests++; if (sram_we !== 1'b0 || sram_addr !== 17'h01000 || cpu_rd_done !== 1'b0)
      begin fails++; $display("FAIL raw_read_slot got we %b addr %h done %b exp 0 01000 0", sram_we, sram_addr, cpu_rd_done); end
    tick;
    @(negedge clk);
    tests++; if (cpu_rd_done !== 1'b1 || cpu_busy !== 1'b0) begin fails++; $display("FAIL raw_done got done %b busy %b exp 1 0", cpu_rd_done, cpu_busy); end
    tests++; if (cpu_rd_data !== 8'hAB) begin fails++; $display("FAIL raw_rd_data got %h exp ab", cpu_rd_data); end
    tick;
    @(negedge clk);
    tests++; if (cpu_rd_done !== 1'b0 || cpu_rd_data !== 8'hAB) begin fails++; $display("FAIL raw_hold got done %b data %h exp 0 ab", cpu_rd_done, cpu_rd_data); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL raw_done_pulses got %0d exp 1", done_cnt); end
    tests++; if (log_addr.size() !== 1) begin fails++; $display("FAIL raw_write_count got %0d exp 1", log_addr.size()); end
  endtask

  task automatic test_rd_repeat;
    tick;
    gpu_req = 1'b1; cpu_rd_start = 1'b1; cpu_rd_addr = 17'h00777;
    tick;
    cpu_rd_addr = 17'h00888;
    @(negedge clk);
    tests++; if (cpu_busy !== 1'b1) begin fails++; $display("FAIL rep_busy got %b exp 1", cpu_busy); end
    tick; tick; tick;
    cpu_rd_start = 1'b0; gpu_req = 1'b0; done_cnt = 0;
    @(negedge clk);
    tests++; if (sram_addr !== 17'h00777 || sram_we !== 1'b0) begin fails++; $display("FAIL rep_addr got %h we %b exp 00777 0", sram_addr, sram_we); end
    tick;
    @(negedge clk);
    tests++; if (cpu_rd_done !== 1'b1 || cpu_rd_data !== 8'h4C) begin fails++; $display("FAIL rep_data got done %b data %h exp 1 4c", cpu_rd_done, cpu_rd_data); end
    tick; tick; tick;
    @(negedge clk);
    tests++; if (done_cnt !== 1 || cpu_busy !== 1'b0) begin fails++; $display("FAIL rep_single_done got %0d busy %b exp 1 0", done_cnt, cpu_busy); end
  endtask

  task automatic test_reset_mid;
    tick;
    gpu_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1'b1; cpu_wr_addr = 17'(32'h2000 + i); cpu_wr_data = 8'(8'hE0 + i);
      tick;
    end
    cpu_wr_valid = 1'b0; cpu_rd_start = 1'b1; cpu_rd_addr = 17'h02000;
    tick;
    cpu_rd_start = 1'b0;
    @(negedge clk);
    tests++; if (fifo_level !== 3'd3 || cpu_busy !== 1'b1) begin fails++; $display("FAIL mid_pre got level %0d busy %b exp 3 1", fifo_level, cpu_busy); end
    #1 reset = 1'b1; gpu_req = 1'b0;
    #1;
    tests++; if (fifo_level !== 3'd0 || cpu_busy !== 1'b0 || sram_we !== 1'b0)
      begin fails++; $display("FAIL mid_reset got level %0d busy %b we %b exp 0 0 0", fifo_level, cpu_busy, sram_we); end
    clear_log(); done_cnt = 0;
    tick;
    reset = 1'b0;
    repeat (5) begin @(negedge clk); tick; end
    @(negedge clk);
    tests++; if (log_addr.size() !== 0) begin fails++; $display("FAIL mid_no_write got %0d exp 0", log_addr.size()); end
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL mid_no_done got %0d exp 0", done_cnt); end
    tests++; if (mem[17'h02000] !== 8'h1C) begin fails++; $display("FAIL mid_mem got %h exp 1c", mem[17'h02000]); end
    tests++; if (cpu_wr_ready !== 1'b1 || fifo_level !== 3'd0) begin fails++; $display("FAIL mid_after got ready %b level %0d exp 1 0", cpu_wr_ready, fifo_level); end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = pat(17'(i));
    test_reset();
    test_fifo_full();
    test_alternating();
    test_read_after_write();
    test_rd_repeat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_sram_arbiter.md
# pixel_sram_arbiter

Shares the single-port pixel-plane framebuffer SRAM (320×240, 8-bit RGB332, 17-bit address) between the pixel engine and the CPU. The pixel engine has absolute priority and sees a zero-latency combinational read path. CPU writes are buffered in a small FIFO. Buffered writes and single CPU reads are slotted into cycles the pixel engine does not claim: blanking, the second pixel of each horizontal pair, and the line-buffer lines. The block sits between the GPU pixel engine, the CPU memory bus bridge and the framebuffer SRAM.

## Interface
- ADDR_W, 17, SRAM address width
- DATA_W, 8, SRAM data width
- FIFO_DEPTH, 4, CPU write FIFO entries (power of two, ≥2)

- clk  in  1  single clock for all logic (GPU pixel clock domain)
- reset  in  1  asynchronous, active-high reset
- gpu_req  in  1  pixel engine needs the SRAM this cycle
- gpu_addr  in  ADDR_W  pixel engine read address
- gpu_data  out  DATA_W  read data to pixel engine (combinational)
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  write accepted on edge where valid&ready
- cpu_wr_addr  in  ADDR_W  write address
- cpu_wr_data  in  DATA_W  write data
- cpu_rd_start  in  1  single-cycle read request, sampled only when !cpu_busy
- cpu_rd_addr  in  ADDR_W  read address, sampled with cpu_rd_start
- cpu_busy  out  1  read in flight
- cpu_rd_done  out  1  one-cycle pulse, cpu_rd_data valid
- cpu_rd_data  out  DATA_W  registered read data, held until next read completes
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- wr_stall_cycles  out  16  saturating count of cycles with cpu_wr_valid && !cpu_wr_ready
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_we  out  1  SRAM write enable; the write commits on the rising edge of clk
- sram_rdata  in  DATA_W  SRAM read data, combinational from sram_addr

## Operation
- Arbitration per cycle, combinational, in priority order:
  - GPU: when gpu_req=1, sram_addr=gpu_addr and sram_we=0.
  - CPU read: when gpu_req=0, state RD_PEND and FIFO empty, sram_addr=rd_addr_reg and sram_we=0. On this edge, cpu_rd_data<=sram_rdata and the state moves to IDLE.
  - FIFO drain: when gpu_req=0 and FIFO non-empty, sram_addr=head.addr, sram_wdata=head.data, sram_we=1; pop on this edge.
  - Otherwise: sram_addr=gpu_addr, sram_we=0.
- gpu_data=sram_rdata at all times.
- FSM states:
  - IDLE→RD_PEND on cpu_rd_start; rd_addr_reg<=cpu_rd_addr.
  - RD_PEND→IDLE when the CPU read slot is granted.
  - cpu_rd_start is ignored while RD_PEND.
- cpu_busy=(state==RD_PEND).
- cpu_wr_ready = !full && state==IDLE. Writes are blocked while a read is pending, so the read cannot be starved and read-after-write ordering holds: a read always observes every previously accepted write.
- Push uses the pre-edge full flag only. A pop in the same cycle does not free a slot for a push.
- Simultaneous push and pop when not full: level unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH; the extra level bit distinguishes full from empty.
- wr_stall_cycles increments per stalled cycle and saturates at 0xFFFF.
- Reset mid-operation: pending FIFO writes and any in-flight read are discarded, with no done pulse.

## Timing
- Reset values:
  - FIFO empty, fifo_level=0
  - state IDLE, cpu_busy=0, cpu_rd_done=0, cpu_rd_data=0, wr_stall_cycles=0
  - sram_we=0, sram_addr=gpu_addr
  - cpu_wr_ready=1 (after reset, once state is IDLE and the FIFO is empty)
- GPU path: 0 cycles, combinational address→data.
- Write accepted at edge N. The earliest SRAM commit is at edge N+1, during the cycle after acceptance when gpu_req=0.
- Read started at edge N. The read is performed in the first cycle after N where gpu_req=0 and the FIFO is empty (edge M). At edge M, cpu_rd_data is registered, cpu_rd_done pulses for the cycle after M, and cpu_busy drops in that same cycle.
- With continuous gpu_req=1, CPU operations wait indefinitely. No timeout exists.

## Test plan
- Reset, then idle: all outputs at reset values; sram_addr tracks gpu_addr; gpu_data equals SRAM contents at gpu_addr with 0 latency.
- gpu_req held 1. Push 0x12→addr 5, 0x34→addr 6, 0x56→addr 7, 0x78→addr 8. Then push a fifth write 0x9A→addr 9 → the fifth is stalled: cpu_wr_ready=0, fifo_level=4, wr_stall_cycles counts. Release gpu_req → four writes commit in order on four consecutive edges, sram_we never asserted while gpu_req=1.
- gpu_req alternating 1/0 (pixel-pair pattern) with 6 back-to-back writes → each write lands only in gpu_req=0 cycles; the final SRAM contents match; the GPU reads in gpu_req=1 cycles are never disturbed.
- Write 0xAB→0x1000, then cpu_rd_start at 0x1000 while gpu_req=1 → cpu_busy=1 and cpu_wr_ready=0. After gpu_req drops: write commits first, read next, cpu_rd_data=0xAB, single done pulse.
- cpu_rd_start repeated while busy → ignored; exactly one done pulse; rd_addr_reg unchanged.
- Assert reset with 3 FIFO entries pending and a read in flight → no SRAM write afterwards, no done pulse, fifo_level=0 immediately.
